mlbmp_arbiter: RTL and testbench
================================

# mlbmp_arbiter

Shares the single-port 64 KiB monochrome bitmap screen RAM between display scan-out and a host (CPU) access port. It prefetches one bitmap byte per 16-pixel group ahead of the beam and presents it as `disp_val` to the bitmap pixel serializer. All remaining RAM cycles go to host reads and writes, under a req/ack handshake. It sits between the VGA timing generator (`posx`/`posy`), the screen RAM and the host bus interface.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line (multiple of 16)
- `H_TOTAL`, 800, total pixel clocks per line
- `V_ACTIVE`, 480, visible lines
- `V_TOTAL`, 525, total lines per frame

Ports:
- `clk`  in  1  pixel clock; one cycle per screen pixel
- `rst`  in  1  synchronous, active-high reset
- `posx`  in  10  current horizontal position, 0..H_TOTAL-1
- `posy`  in  9  current vertical position, 0..V_TOTAL-1
- `mem_addr`  out  16  screen RAM address (combinational from the current-cycle grant)
- `mem_we`  out  1  RAM write strobe
- `mem_wdata`  out  8  RAM write data
- `mem_rdata`  in  8  RAM read data, valid the cycle after the address
- `disp_val`  out  8  bitmap byte for the current 16-pixel group
- `host_req`  in  1  host access request; held with `host_we`/`host_addr`/`host_wdata` stable until ack
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  16  host RAM address, unrestricted
- `host_wdata`  in  8  host write data
- `host_ack`  out  1  one-cycle completion pulse
- `host_rdata`  out  8  read data, valid while `host_ack`=1 for a read

## Operation
- **Display address:** for line y and byte column c: `{y[8:1], 2'b00, c[5:0]}`. Columns 0..H_ACTIVE/16-1. Bits [7:6] are always 0.
- **Display fetch slots** (display has absolute priority):
  - Mid-line: `posy < V_ACTIVE`, `posx[3:0]==12`, `posx < H_ACTIVE-16`. Fetch column `posx[9:4]+1` of line `posy`.
  - Line start: `posx == H_TOTAL-4`. Next line ny = `posy+1`, or 0 if `posy == V_TOTAL-1`. Fetch only if ny < V_ACTIVE; column 0 of line ny.
- In a display slot: `mem_we`=0. In the following cycle `mem_rdata` is captured into the prefetch register.
- **`disp_val` load:** from prefetch at the clock edge ending `posx[3:0]==15` (when `posx < H_ACTIVE-1` and `posy < V_ACTIVE`) and at the edge ending `posx == H_TOTAL-1`. Otherwise it holds.
- **Host FSM:** IDLE -> WAIT -> ACK -> IDLE.
  - IDLE: if `host_req`=1 and the cycle is not a display slot, drive `mem_addr`/`mem_we`/`mem_wdata` from the host inputs (issue cycle T) and go to WAIT. If it is a display slot, stay in IDLE.
  - WAIT: capture `mem_rdata` into `host_rdata`, go to ACK. Writes capture a don't-care.
  - ACK: `host_ack`=1 for one cycle, go to IDLE. No issue occurs in WAIT or ACK.
- Idle bus (no slot, no issue): `mem_we`=0, `mem_addr` = last driven value is acceptable, `mem_wdata`=0.

## Timing
- **Reset values:** `disp_val`=0, prefetch=0, `host_ack`=0, `host_rdata`=0, `mem_we`=0, FSM=IDLE.
- **Reset mid-transaction:** the access is abandoned with no ack. A write already issued may have reached RAM. The host must re-request.
- **Display latency:**
  - Issue at `posx[3:0]`=12, data at 13, prefetch valid at 14, `disp_val` valid at `posx[3:0]`=0 of the next group.
  - The line-start fetch at H_TOTAL-4 gives `disp_val` valid at `posx`=0.
- **Host latency:** issue T, `host_ack` at T+2. A request that collides with a display slot issues at T+1, so worst case is req to ack in 3 cycles. Host throughput is one access per 3 cycles.
- **Collision:** when a display slot and `host_req` occur in the same cycle, only the display address reaches RAM.
- Blanking lines (`posy >= V_ACTIVE`, except the line-start fetch for line 0 at `posy == V_TOTAL-1`) generate no display slots.
- `host_req` deasserted in IDLE: no access. `host_req` still high in the ACK cycle: ignored until IDLE.

## Test plan
- **Mid-line fetch:** `posy`=10, `posx`=12 -> `mem_addr`=0x0501, `mem_we`=0. RAM returns 0xA5 at `posx`=13 -> `disp_val`=0xA5 from `posx`=16 through 31.
- **Line start and last lines:**
  - `posy`=9, `posx`=796 -> `mem_addr`=0x0500, `disp_val` valid at `posx`=0.
  - `posy`=479, `posx`=796 -> no fetch.
  - `posy`=524, `posx`=796 -> `mem_addr`=0x0000.
- **Collision:** host write 0x5A to 0x1234 raised at `posx`=12, `posy`=10 -> cycle 12 `mem_addr`=0x0501; cycle 13 `mem_addr`=0x1234, `mem_we`=1, `mem_wdata`=0x5A; `host_ack` at cycle 15; display byte still delivered correctly.
- **Vblank reads:** `posy`=500, back-to-back reads of 0x0000/0x0001/0x0002 returning 0x11/0x22/0x33 -> acks every 3 cycles with matching `host_rdata`.
- **Reset:** assert `rst` in the WAIT state of a read -> no `host_ack`; all outputs at reset values the next cycle; a re-issued read completes normally.
- **Full-frame soak:** random host traffic over a whole frame -> every display byte matches the RAM model, and every host access is acked exactly once with correct data.

Source files
------------

// File: rtl/mlbmp_arbiter.sv
// -----------------------------------------------------------------------------
// mlbmp_arbiter
//
// Shares one single-port 64 KiB bitmap screen RAM between the display scan-out
// and a host access port. One bitmap byte is prefetched per 16-pixel group,
// ahead of the beam, and is presented on disp_val to the pixel serializer.
// Every RAM cycle that is not a display slot is free for host reads and writes.
//
// Ports
//   clk          pixel clock (one cycle per screen pixel)
//   rst          synchronous active-high reset
//   posx, posy   beam position from the VGA timing generator
//   mem_addr     RAM address, combinational from this cycle's grant
//   mem_we       RAM write strobe
//   mem_wdata    RAM write data (0 when no host write is issued)
//   mem_rdata    RAM read data, valid the cycle after its address
//   disp_val     bitmap byte for the current 16-pixel group
//   host_*       host request/ack port (see handshake note below)
//   o_dbg_state  current host FSM state (0 IDLE, 1 WAIT, 2 ACK)
//
// Host handshake: the host raises host_req with host_we/host_addr/host_wdata
// and holds all of them stable until it sees host_ack. host_ack is a one-cycle
// pulse; for reads host_rdata is valid in that cycle. A request that is still
// high during the ack cycle is not re-issued; the host must drop it (or present
// the next request) from the following cycle on. Reset abandons an access in
// flight without an ack.
// -----------------------------------------------------------------------------
module mlbmp_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  posx,
   input  logic [8:0]  posy,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  disp_val,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_ack,
   output logic [7:0]  host_rdata,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } host_state_t;

   localparam logic [9:0] LP_MID_LIMIT = 10'(H_ACTIVE - 16);
   localparam logic [9:0] LP_HACT_M1   = 10'(H_ACTIVE - 1);
   localparam logic [9:0] LP_LS_X      = 10'(H_TOTAL - 4);
   localparam logic [9:0] LP_H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [8:0] LP_V_ACT     = 9'(V_ACTIVE);
   localparam logic [8:0] LP_V_LAST    = 9'(V_TOTAL - 1);

   host_state_t r_state;
   logic        r_pf_cap;
   logic [7:0]  r_prefetch;
   logic [7:0]  r_disp_val;
   logic        r_host_ack;
   logic [7:0]  r_host_rdata;
   logic [15:0] r_last_addr;

   logic        w_slot_mid;
   logic        w_slot_ls;
   logic        w_slot;
   logic        w_issue;
   logic        w_load;
   logic [8:0]  w_next_y;
   logic [5:0]  w_mid_col;
   logic [15:0] w_disp_addr;

   // Mid-line slot fetches the next group's byte four pixels before the group
   // boundary; the line-start slot fetches column 0 of the coming line.
   assign w_mid_col  = posx[9:4] + 6'd1;
   assign w_next_y   = (posy == LP_V_LAST) ? 9'd0 : posy + 9'd1;
   assign w_slot_mid = (posy < LP_V_ACT) && (posx[3:0] == 4'd12) && (posx < LP_MID_LIMIT);
   assign w_slot_ls  = (posx == LP_LS_X) && (w_next_y < LP_V_ACT);
   assign w_slot     = w_slot_mid | w_slot_ls;

   // Two scan lines share one bitmap row; address bits [7:6] stay zero.
   assign w_disp_addr = w_slot_ls ? {w_next_y[8:1], 8'h00}
                                  : {posy[8:1], 2'b00, w_mid_col};

   // Host issues only from IDLE and only in cycles the display does not own.
   assign w_issue = !rst && (r_state == ST_IDLE) && host_req && !w_slot;

   // disp_val advances at the end of every visible group except the last one
   // of the line, and at the end of the line to show column 0 of the next.
   assign w_load = ((posx[3:0] == 4'hF) && (posx < LP_HACT_M1) && (posy < LP_V_ACT))
                   || (posx == LP_H_LAST);

   always_comb begin
      mem_addr  = r_last_addr;
      mem_we    = 1'b0;
      mem_wdata = 8'h00;
      if (w_slot) begin
         mem_addr = w_disp_addr;
      end else if (w_issue) begin
         mem_addr  = host_addr;
         mem_we    = host_we;
         mem_wdata = host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pf_cap     <= 1'b0;
         r_prefetch   <= 8'h00;
         r_disp_val   <= 8'h00;
         r_host_ack   <= 1'b0;
         r_host_rdata <= 8'h00;
         r_last_addr  <= 16'h0000;
      end else begin
         r_last_addr <= mem_addr;
         // RAM data for a display slot arrives one cycle after the slot.
         r_pf_cap    <= w_slot;
         if (r_pf_cap) begin
            r_prefetch <= mem_rdata;
         end
         if (w_load) begin
            r_disp_val <= r_prefetch;
         end
         r_host_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Read data of the issue cycle is on mem_rdata now; for writes
               // this captures a don't-care.
               r_host_rdata <= mem_rdata;
               r_host_ack   <= 1'b1;
               r_state      <= ST_ACK;
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign disp_val    = r_disp_val;
   assign host_ack    = r_host_ack;
   assign host_rdata  = r_host_rdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mlbmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mlbmp_arbiter
//
// Directed bench for mlbmp_arbiter: a behavioural screen RAM with a backdoor
// preload port, a shadow copy of the RAM contents for expectations, directed
// steps for display fetch, line start, collision, vblank reads and reset, and
// a wraparound soak over the end of one frame into the next with random host
// traffic.
// -----------------------------------------------------------------------------
module tb_mlbmp_arbiter;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [9:0]  posx;
   logic [8:0]  posy;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  disp_val;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic [1:0]  dbg_state;

   mlbmp_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .posx        (posx),
      .posy        (posy),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .disp_val    (disp_val),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_ack    (host_ack),
      .host_rdata  (host_rdata),
      .o_dbg_state (dbg_state)
   );

   // ---------------- screen RAM model ----------------
   logic [7:0]  ram    [0:65535];
   logic [7:0]  shadow [0:65535];
   logic [7:0]  ram_q;
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;

   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
   end
   assign mem_rdata = ram_q;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the rising edge; outputs are checked
   // 1 time unit after that.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      shadow[a] = d;
      tick();
      bd_we = 1'b0;
   endtask

   // ---------------- soak state ----------------
   logic        busy;
   logic        ack_seen;
   logic        cur_we;
   int          wait_cnt;
   logic        disp_ok;
   logic [15:0] haddr;
   logic [7:0]  hdata;
   logic [7:0]  exp_d;
   logic [8:0]  ny;
   logic [5:0]  col1;
   logic [7:0]  vb_exp [3];

   initial begin
      rst        = 1'b1;
      posx       = 10'd0;
      posy       = 9'd500;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = 16'h0000;
      host_wdata = 8'h00;
      bd_we      = 1'b0;
      bd_addr    = 16'h0000;
      bd_data    = 8'h00;
      vb_exp[0]  = 8'h11;
      vb_exp[1]  = 8'h22;
      vb_exp[2]  = 8'h33;
      tick();
      tick();

      // Preload display rows used by the soak, the host pool, then the
      // directed-test bytes (held in reset meanwhile).
      for (int c = 0; c < 40; c++) begin
         bd_write({8'hEE, 2'b00, 6'(c)}, 8'($urandom_range(0, 255)));
         bd_write({8'hEF, 2'b00, 6'(c)}, 8'($urandom_range(0, 255)));
         bd_write({8'h00, 2'b00, 6'(c)}, 8'($urandom_range(0, 255)));
         bd_write({8'h01, 2'b00, 6'(c)}, 8'($urandom_range(0, 255)));
      end
      for (int c = 0; c < 64; c++) begin
         bd_write({8'h40, 2'b01, 6'(c)}, 8'($urandom_range(0, 255)));
      end
      bd_write(16'h0000, 8'h11);
      bd_write(16'h0001, 8'h22);
      bd_write(16'h0002, 8'h33);
      bd_write(16'h0500, 8'h77);
      bd_write(16'h0501, 8'hA5);
      bd_write(16'h0502, 8'h3C);
      bd_write(16'hBEEF, 8'hC3);

      // ---- reset state ----
      settle();
      check("rst_disp_val", 16'(disp_val), 16'h00);
      check("rst_host_ack", 16'(host_ack), 16'h0);
      check("rst_host_rdata", 16'(host_rdata), 16'h00);
      check("rst_mem_we", 16'(mem_we), 16'h0);
      check("rst_mem_wdata", 16'(mem_wdata), 16'h00);
      check("rst_state", 16'(dbg_state), 16'h0);

      // ---- mid-line fetch ----
      tick(); rst = 1'b0; posy = 9'd10; posx = 10'd12; settle();
      check("mid_addr", mem_addr, 16'h0501);
      check("mid_we", 16'(mem_we), 16'h0);
      for (int x = 13; x <= 32; x++) begin
         tick(); posx = 10'(x); settle();
         if (x >= 16 && x <= 31) check("mid_disp_a5", 16'(disp_val), 16'h00A5);
         if (x == 32) check("mid_disp_3c", 16'(disp_val), 16'h003C);
      end

      // ---- line start ----
      tick(); posy = 9'd9; posx = 10'd796; settle();
      check("ls_addr", mem_addr, 16'h0500);
      for (int x = 797; x <= 799; x++) begin
         tick(); posx = 10'(x);
      end
      tick(); posx = 10'd0; posy = 9'd10; settle();
      check("ls_disp", 16'(disp_val), 16'h0077);

      // ---- last visible line: no fetch, host gets the cycle ----
      tick(); posy = 9'd479; posx = 10'd796;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'hBEEF; settle();
      check("l479_addr", mem_addr, 16'hBEEF);
      tick(); posx = 10'd797; settle();
      check("l479_ack_wait", 16'(host_ack), 16'h0);
      tick(); posx = 10'd798; settle();
      check("l479_ack", 16'(host_ack), 16'h1);
      check("l479_rdata", 16'(host_rdata), 16'h00C3);
      tick(); posx = 10'd799; host_req = 1'b0; settle();
      check("l479_ack_drop", 16'(host_ack), 16'h0);

      // ---- last frame line: fetch line 0, host deferred one cycle ----
      tick(); posy = 9'd524; posx = 10'd796;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0001; settle();
      check("l524_addr", mem_addr, 16'h0000);
      check("l524_we", 16'(mem_we), 16'h0);
      tick(); posx = 10'd797; settle();
      check("l524_host_addr", mem_addr, 16'h0001);
      tick(); posx = 10'd798; settle();
      check("l524_ack_wait", 16'(host_ack), 16'h0);
      tick(); posx = 10'd799; settle();
      check("l524_ack", 16'(host_ack), 16'h1);
      check("l524_rdata", 16'(host_rdata), 16'h0022);
      tick(); posx = 10'd0; posy = 9'd0; host_req = 1'b0; settle();
      check("l0_disp", 16'(disp_val), 16'h0011);

      // ---- collision: host write raised on a display slot ----
      tick(); posy = 9'd10; posx = 10'd12;
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h5A; settle();
      check("col_disp_addr", mem_addr, 16'h0501);
      check("col_disp_we", 16'(mem_we), 16'h0);
      tick(); posx = 10'd13; settle();
      check("col_host_addr", mem_addr, 16'h1234);
      check("col_host_we", 16'(mem_we), 16'h1);
      check("col_host_wdata", 16'(mem_wdata), 16'h005A);
      tick(); posx = 10'd14; settle();
      check("col_ack_wait", 16'(host_ack), 16'h0);
      tick(); posx = 10'd15; settle();
      check("col_ack", 16'(host_ack), 16'h1);
      tick(); posx = 10'd16; host_req = 1'b0; host_we = 1'b0; host_wdata = 8'h00; settle();
      check("col_disp", 16'(disp_val), 16'h00A5);
      check("col_ram", 16'(ram[16'h1234]), 16'h005A);

      // ---- vblank back-to-back reads ----
      posy = 9'd500;
      for (int i = 0; i < 3; i++) begin
         tick(); posx = 10'(100 + 3 * i); host_req = 1'b1; host_we = 1'b0;
         host_addr = 16'(i); settle();
         check("vb_issue_addr", mem_addr, 16'(i));
         tick(); posx = 10'(101 + 3 * i); settle();
         check("vb_ack_wait", 16'(host_ack), 16'h0);
         tick(); posx = 10'(102 + 3 * i); settle();
         check("vb_ack", 16'(host_ack), 16'h1);
         check("vb_rdata", 16'(host_rdata), 16'(vb_exp[i]));
      end
      tick(); posx = 10'd109; host_req = 1'b0; settle();
      check("vb_idle_ack", 16'(host_ack), 16'h0);

      // ---- reset during WAIT of a read ----
      tick(); posx = 10'd110; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0002; settle();
      tick(); posx = 10'd111; rst = 1'b1; host_req = 1'b0; settle();
      check("rstw_state_wait", 16'(dbg_state), 16'h1);
      tick(); posx = 10'd112; rst = 1'b0; settle();
      check("rstw_ack", 16'(host_ack), 16'h0);
      check("rstw_rdata", 16'(host_rdata), 16'h00);
      check("rstw_state", 16'(dbg_state), 16'h0);
      check("rstw_disp", 16'(disp_val), 16'h00);
      check("rstw_we", 16'(mem_we), 16'h0);
      tick(); posx = 10'd113; settle();
      check("rstw_no_ack", 16'(host_ack), 16'h0);
      tick(); posx = 10'd114; host_req = 1'b1; host_addr = 16'h0002; settle();
      check("rstw_reissue_addr", mem_addr, 16'h0002);
      tick(); posx = 10'd115;
      tick(); posx = 10'd116; settle();
      check("rstw_reissue_ack", 16'(host_ack), 16'h1);
      check("rstw_reissue_rdata", 16'(host_rdata), 16'h0033);
      tick(); posx = 10'd117; host_req = 1'b0;

      // ---- wraparound soak: lines 476..524 and 0..3 with random host traffic ----
      busy     = 1'b0;
      ack_seen = 1'b0;
      cur_we   = 1'b0;
      wait_cnt = 0;
      disp_ok  = 1'b0;
      tick(); posy = 9'd476; posx = 10'd0;
      for (int n = 0; n < 53 * 800; n++) begin
         if (n != 0) begin
            tick();
            if (posx == 10'd799) begin
               posx    = 10'd0;
               posy    = (posy == 9'd524) ? 9'd0 : posy + 9'd1;
               disp_ok = 1'b1;
            end else begin
               posx = posx + 10'd1;
            end
         end
         if (ack_seen) begin
            busy     = 1'b0;
            ack_seen = 1'b0;
            host_req = 1'b0;
         end
         if (!busy && $urandom_range(0, 2) == 0) begin
            cur_we = 1'($urandom_range(0, 1));
            if (cur_we || $urandom_range(0, 1) == 0)
               haddr = {8'h40, 2'b01, 6'($urandom_range(0, 63))};
            else
               haddr = {8'h00, 2'b00, 6'($urandom_range(0, 39))};
            hdata = 8'($urandom_range(0, 255));
            if (cur_we) begin
               exp_q.push_back(8'h00);
               shadow[haddr] = hdata;
            end else begin
               exp_q.push_back(shadow[haddr]);
            end
            host_req   = 1'b1;
            host_we    = cur_we;
            host_addr  = haddr;
            host_wdata = cur_we ? hdata : 8'h00;
            busy       = 1'b1;
            wait_cnt   = 0;
         end
         settle();

         // display byte on screen
         if (disp_ok && posy < 9'd480 && posx < 10'd640)
            check("soak_disp", 16'(disp_val), 16'(shadow[{posy[8:1], 2'b00, posx[9:4]}]));

         // display slots own the bus
         ny   = (posy == 9'd524) ? 9'd0 : posy + 9'd1;
         col1 = posx[9:4] + 6'd1;
         if (posy < 9'd480 && posx[3:0] == 4'd12 && posx < 10'd624) begin
            check("soak_mid_addr", mem_addr, {posy[8:1], 2'b00, col1});
            check("soak_mid_we", 16'(mem_we), 16'h0);
         end
         if (posx == 10'd796 && ny < 9'd480) begin
            check("soak_ls_addr", mem_addr, {ny[8:1], 8'h00});
            check("soak_ls_we", 16'(mem_we), 16'h0);
         end

         // host completion
         if (busy) begin
            wait_cnt++;
            if (host_ack) begin
               exp_d = exp_q.pop_front();
               check("soak_ack_lat", 16'(wait_cnt >= 3 && wait_cnt <= 4), 16'h1);
               if (!cur_we) check("soak_rdata", 16'(host_rdata), 16'(exp_d));
               ack_seen = 1'b1;
            end else if (wait_cnt > 4) begin
               n_checks++;
               n_errors++;
               $error("FAIL soak_ack_timeout observed=no_ack expected=ack_by_cycle_4 addr=%h", host_addr);
               void'(exp_q.pop_front());
               busy     = 1'b0;
               host_req = 1'b0;
            end
         end else begin
            check("soak_spurious_ack", 16'(host_ack), 16'h0);
         end
      end

      tick(); host_req = 1'b0;
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
